// File: rtl/pkt_arbiter_if.sv
// Link bundle for pkt_arbiter: NUM_INPUTS requester streams in, one merged stream out.
// master = requesters plus downstream link (drive vld/data/rdy_in); slave = the arbiter.
interface pkt_arbiter_if #(
  parameter int PACKET_BITS = 72,
  parameter int NUM_INPUTS  = 4
);
  logic [PACKET_BITS-1:0] pkt_data_in [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]  pkt_vld_in;
  logic [NUM_INPUTS-1:0]  pkt_rdy_out;
  logic [PACKET_BITS-1:0] pkt_data_out;
  logic                   pkt_vld_out;
  logic                   pkt_rdy_in;

  modport master (
    output pkt_data_in, pkt_vld_in, pkt_rdy_in,
    input  pkt_rdy_out, pkt_data_out, pkt_vld_out
  );

  modport slave (
    input  pkt_data_in, pkt_vld_in, pkt_rdy_in,
    output pkt_rdy_out, pkt_data_out, pkt_vld_out
  );
endinterface

// File: rtl/pkt_arbiter.sv
// Round-robin packet merger: 1-cycle latency, 1 packet/cycle with registered output.
// Backpressure: a one-entry park buffer absorbs a stalled link; inputs see rdy=0 while it is full.
module pkt_arbiter #(
  parameter int PACKET_BITS = 72,
  parameter int NUM_INPUTS  = 4,
  parameter int CNT_BITS    = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_INPUTS-1:0]         cfg_en_in,
  input  logic                          cnt_clr_in,
  pkt_arbiter_if.slave                  link,
  output logic [CNT_BITS-1:0]           pkt_cnt_out,
  output logic [$clog2(NUM_INPUTS)-1:0] last_gnt_out
);
  localparam int IDX_BITS = $clog2(NUM_INPUTS);
  typedef logic [PACKET_BITS-1:0] pkt_t;

  logic [NUM_INPUTS-1:0] req;
  logic [IDX_BITS-1:0]   rr_ptr;
  logic [IDX_BITS-1:0]   winner;
  logic [IDX_BITS-1:0]   win_hi;
  logic [IDX_BITS-1:0]   win_lo;
  logic                  found_hi;
  logic                  accept;
  logic                  out_busy;
  logic                  xfer_out;
  logic                  park_vld;
  logic                  out_vld;
  pkt_t                  park_dat;
  pkt_t                  out_dat;
  pkt_t                  win_dat;

  assign req = link.pkt_vld_in & cfg_en_in;

  // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_lo = IDX_BITS'(i);
        if (i >= int'(rr_ptr)) begin
          win_hi   = IDX_BITS'(i);
          found_hi = 1'b1;
        end
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

  assign accept           = resetn && !park_vld && (|req);
  assign link.pkt_rdy_out = accept ? (NUM_INPUTS'(1) << winner) : '0;
  assign win_dat          = link.pkt_data_in[winner];

  assign out_busy          = out_vld && !link.pkt_rdy_in;
  assign xfer_out          = out_vld && link.pkt_rdy_in;
  assign link.pkt_vld_out  = out_vld;
  assign link.pkt_data_out = out_dat;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_vld      <= 1'b0;
      park_vld     <= 1'b0;
      rr_ptr       <= '0;
      last_gnt_out <= '0;
    end else begin
      if (accept) begin
        rr_ptr       <= (winner == IDX_BITS'(NUM_INPUTS - 1)) ? '0 : winner + 1'b1;
        last_gnt_out <= winner;
        if (out_busy) begin
          park_vld <= 1'b1;
        end else begin
          out_vld <= 1'b1;
        end
      end else if (!out_busy) begin
        out_vld  <= park_vld;
        park_vld <= 1'b0;
      end
    end
  end

  // Payload registers carry no reset; validity lives in out_vld/park_vld.
  always_ff @(posedge clk) begin
    if (accept && out_busy) begin
      park_dat <= win_dat;
    end
    if (!out_busy) begin
      if (accept) begin
        out_dat <= win_dat;
      end else if (park_vld) begin
        out_dat <= park_dat;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt_out <= '0;
    end else if (cnt_clr_in) begin
      pkt_cnt_out <= '0;
    end else if (xfer_out && (pkt_cnt_out != '1)) begin
      pkt_cnt_out <= pkt_cnt_out + 1'b1;
    end
  end
endmodule

// File: tb/tb_pkt_arbiter.sv
// Self-checking bench for pkt_arbiter: vector table, directed corner sequences, and random
// traffic checked against a queue-based reference model of the merged stream.
module tb_pkt_arbiter;
  localparam int PB = 72;
  localparam int N  = 4;
  localparam int CB = 4;
  localparam int CNT_MAX = (1 << CB) - 1;
  typedef logic [PB-1:0] pkt_t;

  typedef struct {
    logic [N-1:0] en;
    logic [N-1:0] vld;
    logic [N-1:0] exp_rdy;
    logic         exp_vld;
    logic [7:0]   exp_tag;
    logic [1:0]   exp_last;
  } vec_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic [N-1:0]  cfg_en;
  logic          cnt_clr;
  logic [CB-1:0] cnt;
  logic [1:0]    last_gnt;

  pkt_arbiter_if #(.PACKET_BITS(PB), .NUM_INPUTS(N)) pif ();

  pkt_arbiter #(.PACKET_BITS(PB), .NUM_INPUTS(N), .CNT_BITS(CB)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cfg_en_in    (cfg_en),
    .cnt_clr_in   (cnt_clr),
    .link         (pif),
    .pkt_cnt_out  (cnt),
    .last_gnt_out (last_gnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Upstream sources: per-input FIFO of packets still to be offered.
  pkt_t src_mem [N][64];
  int   src_wr  [N];
  int   src_rd  [N];

  // Reference model: packets held inside the block, in delivery order (output, then park).
  pkt_t mq[$];
  int   m_rr, m_last, m_cnt;

  logic [N-1:0] ob_rdy[$];
  logic         ob_vld[$];
  pkt_t         ob_dat[$];

  task automatic chk(input string name, input pkt_t act, input pkt_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic pkt_t tag_pkt(input int i);
    return {64'hA5A5_5A5A_0F0F_F0F0, 8'(i)};
  endfunction

  function automatic int pick(input logic [N-1:0] rq, input int rr);
    for (int k = 0; k < N; k++) begin
      if (rq[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  task automatic push(input int i, input pkt_t d);
    src_mem[i][src_wr[i] % 64] = d;
    src_wr[i]++;
  endtask

  task automatic model_reset();
    mq.delete();
    m_rr = 0;
    m_last = 0;
    m_cnt = 0;
  endtask

  task automatic ob_clear();
    ob_rdy.delete();
    ob_vld.delete();
    ob_dat.delete();
  endtask

  task automatic tick();
    logic [N-1:0] rq, exp_rdy;
    int w;
    bit acc, xfer;
    for (int i = 0; i < N; i++) begin
      pif.pkt_vld_in[i]  = (src_rd[i] != src_wr[i]);
      pif.pkt_data_in[i] = src_mem[i][src_rd[i] % 64];
    end
    @(negedge clk);
    rq = pif.pkt_vld_in & cfg_en;
    w = pick(rq, m_rr);
    acc = (w >= 0) && (mq.size() < 2);
    exp_rdy = acc ? (N'(1) << w) : '0;
    chk("rdy_out", PB'(pif.pkt_rdy_out), PB'(exp_rdy));
    chk("vld_out", PB'(pif.pkt_vld_out), PB'(mq.size() > 0));
    if (mq.size() > 0) chk("data_out", pif.pkt_data_out, mq[0]);
    chk("cnt", PB'(cnt), PB'(m_cnt));
    chk("last_gnt", PB'(last_gnt), PB'(m_last));
    ob_rdy.push_back(pif.pkt_rdy_out);
    ob_vld.push_back(pif.pkt_vld_out);
    ob_dat.push_back(pif.pkt_data_out);
    xfer = (mq.size() > 0) && pif.pkt_rdy_in;
    if (xfer) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(pif.pkt_data_in[w]);
      m_rr = (w + 1) % N;
      m_last = w;
      src_rd[w]++;
    end
    if (cnt_clr) m_cnt = 0;
    else if (xfer && m_cnt < CNT_MAX) m_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic hard_reset();
    pif.pkt_vld_in = '0;
    #2 resetn = 1'b0;
    for (int i = 0; i < N; i++) src_rd[i] = src_wr[i];
    model_reset();
    @(posedge clk);
    #3 resetn = 1'b1;
  endtask

  vec_t vt[14];
  pkt_t pa, pb, pc, pd;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{4'hB, 4'hF, 4'h1, 1'b0, 8'd0, 2'd0};
    vt[1]  = '{4'hB, 4'hF, 4'h2, 1'b1, 8'd0, 2'd0};
    vt[2]  = '{4'hB, 4'hF, 4'h8, 1'b1, 8'd1, 2'd1};
    vt[3]  = '{4'hB, 4'hF, 4'h1, 1'b1, 8'd3, 2'd3};
    vt[4]  = '{4'hB, 4'hF, 4'h2, 1'b1, 8'd0, 2'd0};
    vt[5]  = '{4'hB, 4'hF, 4'h8, 1'b1, 8'd1, 2'd1};
    vt[6]  = '{4'hF, 4'hF, 4'h1, 1'b1, 8'd3, 2'd3};
    vt[7]  = '{4'hF, 4'hF, 4'h2, 1'b1, 8'd0, 2'd0};
    vt[8]  = '{4'hF, 4'hF, 4'h4, 1'b1, 8'd1, 2'd1};
    vt[9]  = '{4'hF, 4'h8, 4'h8, 1'b1, 8'd2, 2'd2};
    vt[10] = '{4'hF, 4'h9, 4'h1, 1'b1, 8'd3, 2'd3};
    vt[11] = '{4'hF, 4'h9, 4'h8, 1'b1, 8'd0, 2'd0};
    vt[12] = '{4'hF, 4'h0, 4'h0, 1'b1, 8'd3, 2'd3};
    vt[13] = '{4'hF, 4'h0, 4'h0, 1'b0, 8'd0, 2'd3};

    for (int i = 0; i < N; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
      pif.pkt_data_in[i] = tag_pkt(i);
    end
    cfg_en = 4'hF;
    cnt_clr = 1'b0;
    pif.pkt_rdy_in = 1'b1;
    pif.pkt_vld_in = 4'hF;
    model_reset();

    // Reset state with all inputs requesting.
    #1 resetn = 1'b0;
    #1;
    chk("rst_vld_out", PB'(pif.pkt_vld_out), PB'(0));
    chk("rst_rdy_out", PB'(pif.pkt_rdy_out), PB'(0));
    chk("rst_cnt", PB'(cnt), PB'(0));
    chk("rst_last_gnt", PB'(last_gnt), PB'(0));
    @(posedge clk);
    @(posedge clk);
    #3 resetn = 1'b1;

    // Vector table: enable mask 1011, re-enable of input 2, wrap and sparse requests.
    for (int r = 0; r < 14; r++) begin
      cfg_en = vt[r].en;
      pif.pkt_vld_in = vt[r].vld;
      @(negedge clk);
      chk("tbl_rdy", PB'(pif.pkt_rdy_out), PB'(vt[r].exp_rdy));
      chk("tbl_vld", PB'(pif.pkt_vld_out), PB'(vt[r].exp_vld));
      if (vt[r].exp_vld) chk("tbl_dat", pif.pkt_data_out, tag_pkt(int'(vt[r].exp_tag)));
      chk("tbl_last", PB'(last_gnt), PB'(vt[r].exp_last));
      @(posedge clk);
      #1;
    end

    hard_reset();

    // Fairness: all inputs continuously valid, link always ready.
    cfg_en = 4'hF;
    pif.pkt_rdy_in = 1'b1;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < N; i++) push(i, {56'(s), 8'(i), 8'h5C});
    ob_clear();
    repeat (9) tick();
    chk("fair_cnt8", PB'(cnt), PB'(8));
    repeat (5) tick();
    for (int k = 0; k < 8; k++) chk("fair_gnt", PB'(ob_rdy[k]), PB'(1 << (k % N)));
    chk("fair_first_vld", PB'(ob_vld[0]), PB'(0));
    for (int k = 1; k < 10; k++) chk("fair_vld", PB'(ob_vld[k]), PB'(1));

    // Backpressure: A on output, B parked, C held back while parked.
    pa = {8'hAA, 64'h1111_2222_3333_4444};
    pb = {8'hBB, 64'h5555_6666_7777_8888};
    pc = {8'hCC, 64'h9999_AAAA_BBBB_CCCC};
    pif.pkt_rdy_in = 1'b0;
    ob_clear();
    push(2, pa);
    tick();
    tick();
    push(3, pb);
    tick();
    push(0, pc);
    tick();
    tick();
    cfg_en = 4'hE;
    pif.pkt_rdy_in = 1'b1;
    tick();
    tick();
    tick();
    chk("bp_gnt_a", PB'(ob_rdy[0]), PB'(4'h4));
    chk("bp_a_out", ob_dat[1], pa);
    chk("bp_gnt_b", PB'(ob_rdy[2]), PB'(4'h8));
    chk("bp_parked_rdy0", PB'(ob_rdy[3]), PB'(0));
    chk("bp_parked_rdy1", PB'(ob_rdy[4]), PB'(0));
    chk("bp_a_still", ob_dat[5], pa);
    chk("bp_b_next", ob_dat[6], pb);
    chk("bp_b_vld", PB'(ob_vld[6]), PB'(1));
    chk("bp_vld_drop", PB'(ob_vld[7]), PB'(0));
    cfg_en = 4'hF;
    repeat (3) tick();

    // Counter saturation and clear coinciding with a transfer.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int k = 0; k < 20; k++) push(1, {32'(k), 32'hC0FFEE00, 8'h01});
    repeat (17) tick();
    chk("cnt_sat", PB'(cnt), PB'(CNT_MAX));
    chk("cnt_pre_clr_vld", PB'(pif.pkt_vld_out), PB'(1));
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_clr_xfer", PB'(cnt), PB'(0));
    repeat (6) tick();

    // Asynchronous reset with a packet on the output and one parked.
    pd = {8'hDD, 64'hDEAD_BEEF_0000_0001};
    pif.pkt_rdy_in = 1'b0;
    push(1, pa);
    tick();
    push(2, pb);
    tick();
    tick();
    push(3, pc);
    pif.pkt_vld_in[3]  = 1'b1;
    pif.pkt_data_in[3] = pc;
    #2 resetn = 1'b0;
    #1;
    chk("arst_vld_out", PB'(pif.pkt_vld_out), PB'(0));
    chk("arst_rdy_out", PB'(pif.pkt_rdy_out), PB'(0));
    model_reset();
    @(posedge clk);
    push(0, pd);
    pif.pkt_rdy_in = 1'b1;
    #3 resetn = 1'b1;
    ob_clear();
    tick();
    tick();
    chk("arst_gnt0", PB'(ob_rdy[0]), PB'(4'h1));
    chk("arst_lat_vld", PB'(ob_vld[1]), PB'(1));
    chk("arst_lat_dat", ob_dat[1], pd);
    repeat (4) tick();

    // Random traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      pif.pkt_rdy_in = ($urandom % 4) != 0;
      if ($urandom % 16 == 0) cfg_en = 4'($urandom);
      else if ($urandom % 8 == 0) cfg_en = 4'hF;
      cnt_clr = ($urandom % 32) == 0;
      for (int i = 0; i < N; i++)
        if ((src_wr[i] - src_rd[i]) < 3 && ($urandom % 2) == 1)
          push(i, {$urandom, $urandom, 8'($urandom)});
      tick();
    end
    cnt_clr = 1'b0;
    cfg_en = 4'hF;
    pif.pkt_rdy_in = 1'b1;
    repeat (20) tick();
    chk("drain_empty", PB'(pif.pkt_vld_out), PB'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
